// File: rtl/dma_pkg.sv
// Shared definitions for the C2H descriptor issuer.
//   BEAT_BYTES      : bytes per beat of the 512-bit C2H stream
//   MAX_DSC_LEN_DEF : default descriptor size limit / alignment boundary
//   c2h_iss_state_t : issuer FSM state encoding
//   dsc_chunk()     : length of the next descriptor for a given address
package dma_pkg;

  localparam int BEAT_BYTES      = 64;
  localparam int MAX_DSC_LEN_DEF = 4096;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    DONE
  } c2h_iss_state_t;

  // Largest chunk that neither exceeds the remaining length nor crosses a
  // max_len boundary. max_len is a power of two, so the offset inside the
  // current window is a mask of the low address bits.
  function automatic logic [31:0] dsc_chunk(input logic [63:0] addr,
                                            input logic [31:0] rem_len,
                                            input logic [31:0] max_len);
    logic [31:0] room;
    room      = max_len - (addr[31:0] & (max_len - 32'd1));
    dsc_chunk = (rem_len < room) ? rem_len : room;
  endfunction

endpackage

// File: rtl/dma_c2h_dsc_issuer_if.sv
// Bundle of the issuer's bus-level signals.
//   s_cmd_*            : write command handshake (addr/len) into the issuer
//   c2h_dsc_byp_*_0    : descriptor bypass toward the DMA engine
//   mon_c2h_*          : passive tap of the C2H stream handshake
// Modports: slave = the issuer, master = whatever drives commands/stream.
interface dma_c2h_dsc_issuer_if;

  logic        s_cmd_valid;
  logic        s_cmd_ready;
  logic [63:0] s_cmd_addr;
  logic [31:0] s_cmd_len;

  logic        c2h_dsc_byp_ready_0;
  logic [63:0] c2h_dsc_byp_addr_0;
  logic [31:0] c2h_dsc_byp_len_0;
  logic        c2h_dsc_byp_load_0;

  logic        mon_c2h_valid;
  logic        mon_c2h_ready;
  logic        mon_c2h_last;

  modport slave (
    input  s_cmd_valid, s_cmd_addr, s_cmd_len,
    output s_cmd_ready,
    input  c2h_dsc_byp_ready_0,
    output c2h_dsc_byp_addr_0, c2h_dsc_byp_len_0, c2h_dsc_byp_load_0,
    input  mon_c2h_valid, mon_c2h_ready, mon_c2h_last
  );

  modport master (
    output s_cmd_valid, s_cmd_addr, s_cmd_len,
    input  s_cmd_ready,
    output c2h_dsc_byp_ready_0,
    input  c2h_dsc_byp_addr_0, c2h_dsc_byp_len_0, c2h_dsc_byp_load_0,
    output mon_c2h_valid, mon_c2h_ready, mon_c2h_last
  );

endinterface

// File: rtl/dma_c2h_dsc_issuer.sv
// C2H descriptor issuer: splits one host write command into descriptors
// that never cross a MAX_DSC_LEN boundary, feeds them to the DMA bypass
// port, then waits until one stream tlast per descriptor has been seen.
// Ports:
//   pcie_clk, pcie_aresetn : clock, async active-low reset
//   bus (slave)            : command, descriptor bypass and stream tap
//   cmd_done               : 1-cycle pulse when a command completes
//   busy                   : FSM not in IDLE
//   dsc_count              : free-running count of issued descriptors
module dma_c2h_dsc_issuer
  import dma_pkg::*;
#(
  parameter int MAX_DSC_LEN = MAX_DSC_LEN_DEF
) (
  input  logic                 pcie_clk,
  input  logic                 pcie_aresetn,
  dma_c2h_dsc_issuer_if.slave  bus,
  output logic                 cmd_done,
  output logic                 busy,
  output logic [31:0]          dsc_count
);

  c2h_iss_state_t state, state_n;

  logic [63:0] cur_addr;
  logic [31:0] rem_len;
  logic [31:0] chunk;
  logic [15:0] issued_cnt;
  logic [15:0] last_cnt;
  logic        load;
  logic        tlast;
  logic        last_match;

  assign chunk = dsc_chunk(cur_addr, rem_len, 32'(MAX_DSC_LEN));
  assign load  = (state == ISSUE) && bus.c2h_dsc_byp_ready_0;
  assign tlast = bus.mon_c2h_valid && bus.mon_c2h_ready && bus.mon_c2h_last;

  // A beat landing in the comparison cycle already closes the gap.
  assign last_match = (last_cnt == issued_cnt) ||
                      (tlast && ((last_cnt + 16'd1) == issued_cnt));

  assign bus.s_cmd_ready        = (state == IDLE);
  assign bus.c2h_dsc_byp_load_0 = load;
  assign bus.c2h_dsc_byp_addr_0 = cur_addr;
  assign bus.c2h_dsc_byp_len_0  = chunk;
  assign busy                   = (state != IDLE);

  always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
    if (!pcie_aresetn) state <= IDLE;
    else               state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (bus.s_cmd_valid)
                   state_n = (bus.s_cmd_len == 32'd0) ? DONE : ISSUE;
      ISSUE:     if (load && (rem_len == chunk)) state_n = WAIT_DATA;
      WAIT_DATA: if (last_match) state_n = DONE;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
    if (!pcie_aresetn) begin
      cur_addr   <= '0;
      rem_len    <= '0;
      issued_cnt <= '0;
      last_cnt   <= '0;
      dsc_count  <= '0;
      cmd_done   <= 1'b0;
    end else begin
      // Registered, so the pulse lands the cycle after DONE.
      cmd_done <= (state == DONE);

      if (state == IDLE && bus.s_cmd_valid) begin
        cur_addr <= bus.s_cmd_addr;
        rem_len  <= bus.s_cmd_len;
      end else if (load) begin
        cur_addr <= cur_addr + 64'(chunk);
        rem_len  <= rem_len - chunk;
      end

      if (state == DONE)  issued_cnt <= '0;
      else if (load)      issued_cnt <= issued_cnt + 16'd1;

      if (load) dsc_count <= dsc_count + 32'd1;

      // Early tlasts (before their descriptor) still count; IDLE beats
      // belong to no command and are dropped.
      if (state == DONE)                 last_cnt <= '0;
      else if (state != IDLE && tlast)   last_cnt <= last_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dma_c2h_dsc_issuer.sv
module tb_dma_c2h_dsc_issuer;

  logic        pcie_clk = 1'b0;
  logic        pcie_aresetn;
  logic        cmd_done;
  logic        busy;
  logic [31:0] dsc_count;
  logic        drv_v, drv_r, drv_l, coinc;

  always #5 pcie_clk = ~pcie_clk;

  dma_c2h_dsc_issuer_if bus();

  // In coincide mode the stream tap mirrors the load strobe so every
  // descriptor handshake carries its own tlast in the same cycle.
  assign bus.mon_c2h_valid = coinc ? bus.c2h_dsc_byp_load_0 : drv_v;
  assign bus.mon_c2h_ready = coinc ? bus.c2h_dsc_byp_load_0 : drv_r;
  assign bus.mon_c2h_last  = coinc ? bus.c2h_dsc_byp_load_0 : drv_l;

  dma_c2h_dsc_issuer #(.MAX_DSC_LEN(4096)) dut (
    .pcie_clk     (pcie_clk),
    .pcie_aresetn (pcie_aresetn),
    .bus          (bus.slave),
    .cmd_done     (cmd_done),
    .busy         (busy),
    .dsc_count    (dsc_count)
  );

  typedef struct packed {
    logic [63:0] a;
    logic [31:0] l;
  } dsc_t;

  dsc_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int unsigned exp_cnt  = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference split: walk the command in 4 KiB windows.
  function automatic int model_cmd(logic [63:0] a_in, logic [31:0] l_in);
    logic [63:0] a, room, c;
    logic [63:0] l;
    dsc_t        d;
    int          n;
    a = a_in; l = 64'(l_in); n = 0;
    while (l != 0) begin
      room = 64'd4096 - (a % 64'd4096);
      c    = (l < room) ? l : room;
      d.a  = a;
      d.l  = c[31:0];
      exp_q.push_back(d);
      a = a + c;
      l = l - c;
      n++;
    end
    return n;
  endfunction

  // Scoreboard monitor: every descriptor handshake pops one expectation.
  always @(negedge pcie_clk) begin : mon
    dsc_t e;
    if (pcie_aresetn === 1'b1 && bus.c2h_dsc_byp_load_0 === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_dsc", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("dsc_addr", bus.c2h_dsc_byp_addr_0, e.a);
        chk("dsc_len",  bus.c2h_dsc_byp_len_0,  64'(e.l));
      end
    end
  end

  task automatic step();
    @(posedge pcie_clk);
    cyc++;
    #1;
  endtask

  task automatic idle_drv();
    bus.s_cmd_valid         = 1'b0;
    bus.s_cmd_addr          = '0;
    bus.s_cmd_len           = '0;
    bus.c2h_dsc_byp_ready_0 = 1'b0;
    drv_v = 1'b0; drv_r = 1'b0; drv_l = 1'b0;
  endtask

  task automatic do_reset();
    pcie_aresetn = 1'b0;
    coinc = 1'b0;
    idle_drv();
    exp_q.delete();
    exp_cnt = 0;
    repeat (3) step();
    chk("rst_load",      bus.c2h_dsc_byp_load_0, 0);
    chk("rst_addr",      bus.c2h_dsc_byp_addr_0, 0);
    chk("rst_len",       bus.c2h_dsc_byp_len_0,  0);
    chk("rst_cmd_done",  cmd_done, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_dsc_count", dsc_count, 0);
    @(negedge pcie_clk);
    pcie_aresetn = 1'b1;
    step();
    @(negedge pcie_clk);
    chk("rst_cmd_ready", bus.s_cmd_ready, 1);
  endtask

  // A tlast while idle must not be charged to the next command.
  task automatic idle_tlast();
    step();
    drv_v = 1'b1; drv_r = 1'b1; drv_l = 1'b1;
    @(negedge pcie_clk);
    chk("idle_tlast_busy", busy, 0);
  endtask

  // mode 0: random tlasts (may precede their descriptor)
  // mode 1: tlast one cycle after each observed load
  // mode 2: tlast coincident with each load
  task automatic run_cmd(input logic [63:0] a, input logic [31:0] l, input int mode,
                         input int rdy_pct, input int hold_low);
    int n, tl_left, pend, loads, t;
    int acc_cyc, last_tl_cyc, last_ld_cyc, done_cyc;
    bit acc, done;
    n = model_cmd(a, l);
    exp_cnt += n;
    tl_left = n; pend = 0; loads = 0;
    last_tl_cyc = 0; last_ld_cyc = 0; done_cyc = 0;

    step();
    idle_drv();
    bus.s_cmd_valid = 1'b1;
    bus.s_cmd_addr  = a;
    bus.s_cmd_len   = l;
    coinc = (mode == 2);
    @(negedge pcie_clk);
    acc = bus.s_cmd_ready;
    t = 0;
    while (!acc && t < 50) begin
      step();
      @(negedge pcie_clk);
      acc = bus.s_cmd_ready;
      t++;
    end
    acc_cyc = cyc;
    if (!acc) begin
      chk("cmd_accept_timeout", 0, 1);
      coinc = 1'b0;
      do_reset();
      return;
    end

    done = 1'b0; t = 0;
    while (!done && t < 2000) begin
      step();
      bus.s_cmd_valid = 1'b0;
      if (t < hold_low) bus.c2h_dsc_byp_ready_0 = 1'b0;
      else bus.c2h_dsc_byp_ready_0 = ($urandom_range(0, 99) < rdy_pct);
      drv_v = 1'b0; drv_r = 1'b0; drv_l = 1'b0;
      if (mode == 0) begin
        if (tl_left > 0 && $urandom_range(0, 3) == 0) begin
          drv_v = 1'b1; drv_r = 1'b1; drv_l = 1'b1;
          tl_left--;
        end else begin
          drv_v = 1'($urandom_range(0, 1));
          drv_r = 1'($urandom_range(0, 1));
        end
      end else if (mode == 1 && pend > 0) begin
        drv_v = 1'b1; drv_r = 1'b1; drv_l = 1'b1;
        pend--; tl_left--;
        last_tl_cyc = cyc;
      end
      @(negedge pcie_clk);
      if (t < hold_low) chk("load_while_not_ready", bus.c2h_dsc_byp_load_0, 0);
      if (bus.c2h_dsc_byp_load_0) begin
        loads++;
        last_ld_cyc = cyc;
        if (mode == 1) pend++;
        if (mode == 2) tl_left--;
      end
      if (cmd_done) begin
        done = 1'b1;
        done_cyc = cyc;
      end
      t++;
    end
    coinc = 1'b0;

    if (!done) begin
      chk("cmd_done_timeout", 0, 1);
      do_reset();
      return;
    end
    chk("dsc_all_issued", exp_q.size(), 0);
    chk("dsc_loads", loads, n);
    chk("tlasts_before_done", tl_left, 0);
    chk("dsc_count", dsc_count, 64'(exp_cnt));
    if (n == 0) chk("len0_done_latency", done_cyc, acc_cyc + 2);
    else if (mode == 1) chk("done_after_tlast", done_cyc, last_tl_cyc + 2);
    else if (mode == 2) chk("done_after_coinc", done_cyc, last_ld_cyc + 3);

    step();
    idle_drv();
    @(negedge pcie_clk);
    chk("done_one_cycle", cmd_done, 0);
    chk("ready_after_done", bus.s_cmd_ready, 1);
    chk("idle_after_done", busy, 0);
  endtask

  // Reset dropped while the 2nd of 3 descriptors is on the bus.
  task automatic abort_cmd();
    int t;
    exp_cnt += model_cmd(64'h0, 32'h3000);
    step();
    idle_drv();
    bus.s_cmd_valid = 1'b1;
    bus.s_cmd_len   = 32'h3000;
    bus.c2h_dsc_byp_ready_0 = 1'b1;
    step();
    bus.s_cmd_valid = 1'b0;
    @(negedge pcie_clk);
    t = 0;
    while (!bus.c2h_dsc_byp_load_0 && t < 20) begin
      step();
      @(negedge pcie_clk);
      t++;
    end
    chk("abort_first_load", bus.c2h_dsc_byp_load_0, 1);
    step();
    pcie_aresetn = 1'b0;
    #1;
    chk("abort_load",      bus.c2h_dsc_byp_load_0, 0);
    chk("abort_addr",      bus.c2h_dsc_byp_addr_0, 0);
    chk("abort_len",       bus.c2h_dsc_byp_len_0, 0);
    chk("abort_busy",      busy, 0);
    chk("abort_dsc_count", dsc_count, 0);
    exp_q.delete();
    exp_cnt = 0;
    repeat (2) step();
    @(negedge pcie_clk);
    pcie_aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge pcie_clk);
      chk("abort_no_done",   cmd_done, 0);
      chk("abort_ready",     bus.s_cmd_ready, 1);
      chk("abort_count_clr", dsc_count, 0);
    end
    idle_drv();
  endtask

  initial begin : stim
    logic [63:0] a;
    logic [31:0] l;
    coinc = 1'b0;
    do_reset();

    run_cmd(64'h1000, 32'h800, 1, 100, 0);
    run_cmd(64'h0F00, 32'h300, 1, 100, 0);
    do_reset();
    run_cmd(64'h0, 32'h2000, 1, 100, 5);
    run_cmd(64'h1234, 32'h0, 1, 100, 0);
    run_cmd(64'h0F80, 32'h100, 2, 100, 0);
    run_cmd(64'h2000, 32'h40, 2, 100, 0);
    run_cmd(64'hFFFF_FFFF_FFFF_FF00, 32'h200, 1, 60, 0);
    idle_tlast();
    run_cmd(64'h5F00, 32'h300, 1, 100, 0);
    abort_cmd();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       a = {$urandom, $urandom};
        1:       a = 64'hFFFF_FFFF_FFFF_F000 + 64'($urandom_range(0, 4095));
        2:       a = {$urandom, $urandom} & ~64'hFFF;
        default: a = 64'($urandom_range(0, 8191));
      endcase
      l = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom_range(1, 32'h3000));
      if ($urandom_range(0, 3) == 0) idle_tlast();
      run_cmd(a, l, $urandom_range(0, 2), $urandom_range(20, 100), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_c2h_dsc_issuer.md
DMA_C2H_DSC_ISSUER -- requirements
Module: dma_c2h_dsc_issuer

Interface
REQ-001 Parameter MAX_DSC_LEN, default 4096, max bytes per descriptor and alignment boundary; SHALL be a power of two.
REQ-002 pcie_clk  in  1  single clock for all logic.
REQ-003 pcie_aresetn  in  1  asynchronous, active-low reset.
REQ-004 s_cmd_valid  in  1  write command valid.
REQ-005 s_cmd_ready  out  1  command accepted when valid and ready are both high.
REQ-006 s_cmd_addr  in  64  host destination byte address.
REQ-007 s_cmd_len  in  32  command length in bytes.
REQ-008 c2h_dsc_byp_ready_0  in  1  descriptor bypass ready from the DMA engine.
REQ-009 c2h_dsc_byp_addr_0  out  64  descriptor destination address.
REQ-010 c2h_dsc_byp_len_0  out  32  descriptor length in bytes.
REQ-011 c2h_dsc_byp_load_0  out  1  descriptor load strobe.
REQ-012 mon_c2h_valid, mon_c2h_ready, mon_c2h_last  in  1 each  passive tap of the C2H 512-bit stream handshake.
REQ-013 cmd_done  out  1  one-cycle pulse when the current command is complete.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 dsc_count  out  32  free-running count of issued descriptors, wraps at 2^32.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT_DATA and DONE.
REQ-017 s_cmd_ready SHALL be high only in IDLE.
REQ-018 On acceptance, the module SHALL latch cur_addr and rem_len and move to ISSUE; if s_cmd_len = 0 it SHALL move to DONE instead.
REQ-019 In ISSUE, chunk SHALL equal min(rem_len, MAX_DSC_LEN - (cur_addr mod MAX_DSC_LEN)), so no descriptor crosses a MAX_DSC_LEN boundary.
REQ-020 In ISSUE, c2h_dsc_byp_load_0 SHALL equal c2h_dsc_byp_ready_0; addr and len SHALL be cur_addr and chunk, driven from registers or a pure function of registers.
REQ-021 Descriptor handshake: on load high, cur_addr += chunk, rem_len -= chunk, issued_cnt += 1, dsc_count += 1.
REQ-022 When rem_len reaches 0, the FSM SHALL move ISSUE -> WAIT_DATA.
REQ-023 The first load SHALL be possible no earlier than the cycle after command acceptance.
REQ-024 last_cnt SHALL increment on each cycle with mon_c2h_valid & mon_c2h_ready & mon_c2h_last, in any state other than IDLE.
REQ-025 The FSM SHALL move WAIT_DATA -> DONE when last_cnt = issued_cnt; this includes a last beat arriving in the same cycle as the comparison.
REQ-026 A tlast that arrives before its descriptor SHALL still be counted; the DONE condition is evaluated only in WAIT_DATA.
REQ-027 DONE SHALL assert cmd_done for exactly one cycle, clear issued_cnt and last_cnt, and return to IDLE.
REQ-028 A tlast observed in IDLE SHALL be ignored and SHALL NOT be counted.
REQ-029 issued_cnt and last_cnt SHALL be 16 bits wide; rem_len SHALL be 32 bits; addresses SHALL wrap modulo 2^64 without error.

Reset
REQ-030 While pcie_aresetn is low, all state SHALL clear immediately: FSM = IDLE, load = 0, addr = 0, len = 0, cmd_done = 0, busy = 0, dsc_count = 0, all counters = 0.
REQ-031 Reset mid-command SHALL abandon the command with no cmd_done pulse.
REQ-032 s_cmd_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-033 Package dma_pkg SHALL hold BEAT_BYTES = 64, the default MAX_DSC_LEN, and the enum typedef c2h_iss_state_t.
REQ-034 The block SHALL be a single module with no sub-module; the chunk computation SHALL be a function in dma_pkg.

Verification
REQ-035 Command addr 0x1000, len 0x800 -> one descriptor (0x1000, 0x800); cmd_done one cycle after DONE is entered, which follows one tlast.
REQ-036 Command addr 0x0F00, len 0x300 -> descriptors (0x0F00, 0x100) then (0x1000, 0x200); cmd_done only after the 2nd tlast.
REQ-037 Command addr 0x0, len 0x2000, ready held low for 5 cycles -> load stays 0 for those cycles; then (0x0, 0x1000) and (0x1000, 0x1000); dsc_count = 2.
REQ-038 Command with len 0 -> no load; cmd_done pulses 2 cycles after acceptance; s_cmd_ready returns to 1.
REQ-039 pcie_aresetn pulled low in ISSUE after 1 of 3 descriptors -> load = 0 in the same cycle, no cmd_done; after release, s_cmd_ready = 1 and dsc_count = 0.
REQ-040 tlast coinciding with the last descriptor load -> WAIT_DATA entered, then DONE on the next cycle with no hang.
